// File: rtl/rb_window_sink_pkg.sv
// Shared parameters and FSM encoding for the row-buffer window sink.
// Holds default geometry, derived widths and the frame-control state type.
package rb_window_sink_pkg;

  localparam int K_DEF           = 5;
  localparam int PIXEL_WIDTH_DEF = 8;
  localparam int IMG_WIDTH_DEF   = 128;
  localparam int IMG_HEIGHT_DEF  = 128;
  localparam int SUM_WIDTH_DEF   = PIXEL_WIDTH_DEF + $clog2(K_DEF * K_DEF);
  localparam int N_OUT_DEF       = (IMG_WIDTH_DEF - K_DEF + 1) * (IMG_HEIGHT_DEF - K_DEF + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rb_window_sink_column_adder.sv
// Stage 1 of the window pipeline: sums the K pixels of one column and
// registers the result when the column is accepted.
module rb_column_adder #(
  parameter int K           = 5,
  parameter int PIXEL_WIDTH = 8,
  parameter int CSUM_WIDTH  = PIXEL_WIDTH + $clog2(K)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [K*PIXEL_WIDTH-1:0] col_data,
  output logic [CSUM_WIDTH-1:0]    colsum
);

  logic [CSUM_WIDTH-1:0] sum_c;

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < K; i++) begin
      sum_c = sum_c + CSUM_WIDTH'(col_data[i*PIXEL_WIDTH +: PIXEL_WIDTH]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      colsum <= '0;
    end else if (en) begin
      colsum <= sum_c;
    end
  end

endmodule

// File: rtl/rb_window_sink.sv
// Consumer of the row-buffer column stream: slides a KxK window along each
// stream row, writes the box sum per output position, and flags frame done.
module rb_window_sink
  import rb_window_sink_pkg::*;
#(
  parameter int K              = K_DEF,
  parameter int PIXEL_WIDTH    = PIXEL_WIDTH_DEF,
  parameter int IMG_WIDTH      = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT     = IMG_HEIGHT_DEF,
  parameter int SUM_WIDTH      = PIXEL_WIDTH + $clog2(K * K),
  parameter int OUT_ADDR_WIDTH = $clog2((IMG_WIDTH - K + 1) * (IMG_HEIGHT - K + 1))
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      col_valid,
  input  logic [K*PIXEL_WIDTH-1:0]  col_data,
  output logic                      wr_en,
  output logic [OUT_ADDR_WIDTH-1:0] wr_addr,
  output logic [SUM_WIDTH-1:0]      wr_data,
  output logic                      busy,
  output logic                      done
);

  localparam int CSUM_WIDTH = PIXEL_WIDTH + $clog2(K);
  localparam int CW         = $clog2(IMG_WIDTH);
  localparam int RW         = $clog2(IMG_HEIGHT - K + 2);
  localparam logic [CW-1:0] COL_LAST     = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] COL_FIRST_WR = CW'(K - 1);
  localparam logic [RW-1:0] ROW_LAST     = RW'(IMG_HEIGHT - K);

  state_t                state, state_nxt;
  logic [CW-1:0]         col_cnt;
  logic [RW-1:0]         row_cnt;
  logic                  drain_cnt;
  logic                  accept, advance, last_col, frame_start;
  logic [CSUM_WIDTH-1:0] colsum;
  logic                  s1_valid, s1_first, s1_write;
  logic [SUM_WIDTH-1:0]  win_sum, sum_nxt;
  logic [CSUM_WIDTH-1:0] hist [K];

  // Pipeline moves only on an accepted column or while draining, so gaps freeze it.
  assign accept      = (state == ST_RUN) && col_valid;
  assign advance     = accept || (state == ST_DRAIN);
  assign last_col    = accept && (col_cnt == COL_LAST) && (row_cnt == ROW_LAST);
  assign frame_start = start && ((state == ST_IDLE) || (state == ST_DONE));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_RUN;
      ST_RUN:   if (last_col) state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_cnt) state_nxt = ST_DONE;
      ST_DONE:  if (start) state_nxt = ST_RUN;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_RUN) || (state == ST_DRAIN);
    done = (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      col_cnt   <= '0;
      row_cnt   <= '0;
      drain_cnt <= 1'b0;
    end else begin
      if (accept) begin
        if (col_cnt == COL_LAST) begin
          col_cnt <= '0;
          row_cnt <= row_cnt + RW'(1);
        end else begin
          col_cnt <= col_cnt + CW'(1);
        end
      end
      if (state == ST_DRAIN) drain_cnt <= ~drain_cnt;
    end
  end

  rb_column_adder #(
    .K           (K),
    .PIXEL_WIDTH (PIXEL_WIDTH),
    .CSUM_WIDTH  (CSUM_WIDTH)
  ) u_column_adder (
    .clk      (clk),
    .rst      (rst),
    .en       (accept),
    .col_data (col_data),
    .colsum   (colsum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_write <= 1'b0;
    end else if (advance) begin
      s1_valid <= accept;
      s1_first <= (col_cnt == '0);
      s1_write <= (col_cnt >= COL_FIRST_WR);
    end
  end

  // Modular arithmetic is fine: the true window sum always fits SUM_WIDTH.
  always_comb begin
    if (s1_first) sum_nxt = SUM_WIDTH'(colsum);
    else          sum_nxt = win_sum + SUM_WIDTH'(colsum) - SUM_WIDTH'(hist[K-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_sum <= '0;
      wr_en   <= 1'b0;
      wr_data <= '0;
      for (int i = 0; i < K; i++) hist[i] <= '0;
    end else begin
      wr_en <= 1'b0;
      if (advance && s1_valid) begin
        win_sum <= sum_nxt;
        hist[0] <= colsum;
        for (int i = 1; i < K; i++) hist[i] <= s1_first ? '0 : hist[i-1];
        if (s1_write) begin
          wr_en   <= 1'b1;
          wr_data <= sum_nxt;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || frame_start) wr_addr <= '0;
    else if (wr_en)         wr_addr <= wr_addr + OUT_ADDR_WIDTH'(1);
  end

endmodule

// File: tb/tb_rb_window_sink.sv
// Bench for rb_window_sink on an 8x6 image with K=5: random and patterned
// frames, gaps, stray start/col_valid, and a mid-frame reset.
module tb_rb_window_sink;

  localparam int K     = 5;
  localparam int PW    = 8;
  localparam int W     = 8;
  localparam int H     = 6;
  localparam int SW    = PW + $clog2(K * K);
  localparam int N_OUT = (W - K + 1) * (H - K + 1);
  localparam int AW    = $clog2(N_OUT);
  localparam int QW    = AW + SW;

  logic            clk = 1'b0;
  logic            rst, start, col_valid;
  logic [K*PW-1:0] col_data;
  logic            wr_en, busy, done;
  logic [AW-1:0]   wr_addr;
  logic [SW-1:0]   wr_data;

  int              total = 0;
  int              bad   = 0;
  logic [QW-1:0]   exp_q[$];
  logic [PW-1:0]   img [H][W];
  int              exp_addr;

  rb_window_sink #(
    .K(K), .PIXEL_WIDTH(PW), .IMG_WIDTH(W), .IMG_HEIGHT(H)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .col_valid(col_valid), .col_data(col_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic monitor_loop();
    logic [QW-1:0] e;
    forever begin
      @(negedge clk);
      if (wr_en) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: addr=%0d data=%0d with no expected write", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          if ({wr_addr, wr_data} !== e) begin
            bad++;
            $display("FAIL write: got addr=%0d data=%0d want addr=%0d data=%0d",
                     wr_addr, wr_data, e[QW-1:SW], e[SW-1:0]);
          end
        end
      end
    end
  endtask

  // 0: all ones, 1: column index, 2: all 255, 3: random
  task automatic fill_img(input int mode);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (mode)
          0:       img[r][c] = 8'd1;
          1:       img[r][c] = PW'(c);
          2:       img[r][c] = 8'd255;
          default: img[r][c] = PW'($urandom_range(0, 255));
        endcase
  endtask

  function automatic logic [K*PW-1:0] col_of(input int r, input int c);
    logic [K*PW-1:0] v;
    for (int k = 0; k < K; k++) v[k*PW +: PW] = img[r+k][c];
    return v;
  endfunction

  function automatic int win_of(input int r, input int c);
    int s = 0;
    for (int i = 0; i < K; i++)
      for (int j = c - K + 1; j <= c; j++) s += int'(img[r+i][j]);
    return s;
  endfunction

  // gap_mode 0: continuous, 1: one idle cycle per column, 2: random idles
  task automatic run_frame(input int gap_mode, input bit stray_start, input bit abort);
    int n_gap;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_addr = 0;
    for (int r = 0; r <= H - K; r++) begin
      for (int c = 0; c < W; c++) begin
        n_gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
        for (int g = 0; g < n_gap; g++) begin
          col_valid = 1'b0;
          col_data  = (K*PW)'({$urandom, $urandom});
          start     = stray_start && ($urandom_range(0, 1) == 0);
          tick();
          start = 1'b0;
        end
        col_valid = 1'b1;
        col_data  = col_of(r, c);
        start     = stray_start && (c == 3);
        if (c >= K - 1) begin
          exp_q.push_back({AW'(exp_addr), SW'(win_of(r, c))});
          exp_addr++;
        end
        tick();
        start = 1'b0;
        if (abort && r == 1 && c == 5) begin
          col_valid = 1'b0;
          rst = 1'b1;
          tick();
          rst = 1'b0;
          check("abort_wr_en", 32'(wr_en), 0);
          check("abort_wr_addr", 32'(wr_addr), 0);
          check("abort_wr_data", 32'(wr_data), 0);
          check("abort_busy", 32'(busy), 0);
          check("abort_done", 32'(done), 0);
          exp_q.delete();
          return;
        end
      end
    end
    col_valid = 1'b0;
    check("drain0_busy", 32'(busy), 1);
    check("drain0_done", 32'(done), 0);
    tick();
    check("drain1_done", 32'(done), 0);
    tick();
    check("end_done", 32'(done), 1);
    check("end_busy", 32'(busy), 0);
    check("end_queue_empty", 32'(exp_q.size()), 0);
    check("end_wr_addr", 32'(wr_addr), 32'(AW'(N_OUT)));
  endtask

  task automatic poke_col_valid(input int n);
    for (int i = 0; i < n; i++) begin
      col_valid = 1'b1;
      col_data  = (K*PW)'({$urandom, $urandom});
      tick();
    end
    col_valid = 1'b0;
  endtask

  initial begin
    fork
      monitor_loop();
    join_none
    rst = 1'b1; start = 1'b0; col_valid = 1'b0; col_data = '0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("reset_wr_en", 32'(wr_en), 0);
    check("reset_wr_addr", 32'(wr_addr), 0);
    check("reset_wr_data", 32'(wr_data), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    rst = 1'b0;

    poke_col_valid(3);
    check("idle_busy", 32'(busy), 0);

    fill_img(0); run_frame(0, 1'b0, 1'b0);
    fill_img(1); run_frame(0, 1'b0, 1'b0);
    fill_img(2); run_frame(0, 1'b0, 1'b0);
    fill_img(1); run_frame(1, 1'b0, 1'b0);

    poke_col_valid(3);
    check("done_hold", 32'(done), 1);
    check("done_wr_addr", 32'(wr_addr), 32'(AW'(N_OUT)));

    fill_img(1); run_frame(0, 1'b0, 1'b1);
    poke_col_valid(2);
    fill_img(1); run_frame(0, 1'b0, 1'b0);
    fill_img(3); run_frame(2, 1'b1, 1'b0);
    for (int f = 0; f < 3; f++) begin
      fill_img(3);
      run_frame(2, 1'b0, 1'b0);
    end

    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rb_window_sink.md
Name: rb_window_sink

Overview:
- Consumer end of the row-buffer column stream. Accepts one K-pixel vertical column per valid cycle (newest image row plus the K-1 buffered rows) and assembles a sliding KxK window.
- Computes the KxK box sum per output position and writes it to the result memory through a simple write port.
- Sits downstream of the row-buffer top level and upstream of result storage. Signals completion when the full output frame has been written.

Parameters:
- K, 5, window size; column vector holds K pixels.
- PIXEL_WIDTH, 8, bits per pixel.
- IMG_WIDTH, 128, columns per image row.
- IMG_HEIGHT, 128, image rows.
- SUM_WIDTH, PIXEL_WIDTH+$clog2(K*K) (13), width of the window sum.
- OUT_ADDR_WIDTH, $clog2((IMG_WIDTH-K+1)*(IMG_HEIGHT-K+1)), result address width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a frame
- col_valid  in  1  col_data valid this cycle; driven from the row-buffer output-enable condition
- col_data  in  K*PIXEL_WIDTH  column; [K*PW-1 -: PW] is the newest (bottom) row, [PW-1:0] is the oldest (top) row
- wr_en  out  1  result write strobe
- wr_addr  out  OUT_ADDR_WIDTH  result address
- wr_data  out  SUM_WIDTH  window sum
- busy  out  1  high in RUN or DRAIN
- done  out  1  frame complete; held high

Behaviour:
- Reset, applied on the clk edge when rst=1, from any state including mid-frame:
  - State goes to IDLE.
  - wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0.
  - All counters, column-sum history and the window sum are cleared.
- FSM states IDLE, RUN, DRAIN, DONE:
  - IDLE -> RUN on start.
  - RUN -> DRAIN when the last column (col_cnt=IMG_WIDTH-1, row_cnt=IMG_HEIGHT-K) is accepted.
  - DRAIN -> DONE after 2 cycles.
  - DONE -> RUN on start: counters and wr_addr are cleared and done drops. The new frame's first column is accepted from the cycle after start.
- start is ignored in RUN and DRAIN.
- col_valid is ignored outside RUN.
- Column accept happens in RUN with col_valid=1. Gaps (col_valid=0) stall every counter and the pipeline advance; no data is lost.
- Counters:
  - col_cnt runs 0..IMG_WIDTH-1 and wraps to 0.
  - On wrap, row_cnt increments over 0..IMG_HEIGHT-K.
- Stage 1 (registered): colsum = sum of the K pixels, width PIXEL_WIDTH+$clog2(K).
- Stage 2 (registered):
  - If col_cnt was 0, win_sum = colsum and the K-deep colsum history is cleared.
  - Otherwise win_sum = win_sum + colsum - history[K-1], where cleared entries count as 0.
  - The history shifts on each accept.
  - No overflow: SUM_WIDTH holds K*K*(2^PW-1).
- Output:
  - wr_en pulses for one cycle with wr_data=win_sum when the accepted column had col_cnt>=K-1.
  - Latency is 2 cycles after the accept edge (pipeline stalls during gaps, so the write occurs 2 accepted-or-drain cycles later).
  - Rows never mix: the first K-1 columns of each row produce no write.
- wr_addr:
  - Starts at 0 and increments after each write.
  - Final value after the frame is N_OUT=(IMG_WIDTH-K+1)*(IMG_HEIGHT-K+1); the address of the last write is N_OUT-1.
- done rises in the cycle DONE is entered and stays high until start or rst. busy=~done in non-IDLE states.
- Simultaneous rst and start: rst wins.

Decomposition:
- Shared params package (alongside the existing params header) holds K, PIXEL_WIDTH, IMG_WIDTH, IMG_HEIGHT, derived SUM_WIDTH and N_OUT, and the FSM state encodings.
- One natural sub-module: rb_column_adder, the combinational K-input pixel adder with its output register (stage 1).
- FSM, counters, history and the running sum live in the top of this block.

Test Plan:
- All pixels = 1, K=5, W=8, H=6, col_valid continuous -> 8 writes, wr_data=25 each, wr_addr 0..7, done high 2 cycles after the last accept.
- Pixel value = column index (0..7), same geometry -> per row wr_data = 5*(0+1+2+3+4)=50, then 75, 100, 125; pattern repeats for row 2; no write for col_cnt<4.
- All pixels 255 -> wr_data=6375 (13 bits, no wrap) for every write.
- Same stream as test 2 with col_valid low on every other cycle -> identical wr_data/wr_addr sequence, writes spaced accordingly, no extra or missing wr_en.
- rst asserted at row 1, col 5 -> next cycle all outputs 0, state IDLE; new start plus full stream -> 8 correct writes starting at wr_addr 0.
- start pulsed during RUN and col_valid pulsed in IDLE/DONE -> no effect on counters or writes; start in DONE clears done and begins a new frame at wr_addr 0.
